// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush controller for a 5-stage in-order pipeline.
// A data-memory wait freezes the whole pipeline and takes priority over ID-stage
// hazard stalls and branch flushes. A wait that never completes lands in ERROR,
// which holds the pipeline frozen until reset.
// Build option: define PIPE_STALL_STATS_EN to add saturating statistics counters
// (stall_cnt, flush_cnt, wait_cnt). Without it these ports are tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | pipeline flowing; hazard stalls and branch flushes handled here
// MEM_WAIT | MEM-stage access outstanding; pipeline frozen until mem_ready
// ERROR    | memory access timed out; pipeline frozen until rst

module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             idexe_bubble,
  output logic             ifid_flush,
  output logic             back_freeze,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // The timer counts completed not-ready MEM_WAIT cycles. Leaving from the
  // cycle where it reads MEM_TIMEOUT-2 means the increment would reach
  // MEM_TIMEOUT-1, so the whole stall (entry cycle included) lasts MEM_TIMEOUT cycles.
  localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 2);

  state_t     state_q, state_d, state_cur;
  logic [7:0] timer_q, timer_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_hold;

  // Reset forces the outputs to look like RUN during the reset cycle itself.
  always_comb begin
    state_cur = rst ? RUN : state_q;
  end

  // Next-state, timer and freeze/bubble/flush decode; memory freeze wins over ID-stage events.
  always_comb begin
    state_d   = state_cur;
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    mem_hold  = 1'b0;
    case (state_cur)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_hold = 1'b1;
          state_d  = MEM_WAIT;
          timer_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          mem_hold = 1'b1;
          timer_d  = timer_q + 8'd1;
          if (timer_q == TIMER_LAST) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        mem_hold = 1'b1;
      end
      default: begin
        // Unused encoding: freeze for this cycle and recover to RUN.
        mem_hold = 1'b1;
        state_d  = RUN;
      end
    endcase

    pc_freeze    = mem_hold | hazard_detected;
    ifid_freeze  = mem_hold | hazard_detected;
    idexe_bubble = !mem_hold && hazard_detected;
    ifid_flush   = !mem_hold && !hazard_detected && branch_taken;
    back_freeze  = mem_hold;
  end

  // FSM, timer and sticky error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      timer_q   <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign state   = state_cur;
  assign mem_err = mem_err_q && !rst;

`ifdef PIPE_STALL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic             wait_inc;

  // Saturating event counters; wait_cnt counts MEM_WAIT cycles still waiting on memory.
  always_comb begin
    wait_inc    = (state_cur == MEM_WAIT) && !mem_ready;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (pc_freeze && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    if (wait_inc && (wait_cnt_q != CNT_MAX)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed scenarios with literal expectations
// plus a randomized run checked against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, hazard_detected, branch_taken, mem_req, mem_ready;
  logic          pc_freeze, ifid_freeze, idexe_bubble, ifid_flush, back_freeze;
  logic [1:0]    state;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int errors = 0;
  int checks = 0;

  // model: mode 0=running, 1=waiting on memory, 2=timed out
  int m_mode = 0, m_waited = 0, m_stall = 0, m_flush = 0, m_wait = 0;
  bit m_err = 1'b0;

  logic [7:0]      dut_vec;
  logic [3*CW-1:0] dut_cnt;
  assign dut_vec = {pc_freeze, ifid_freeze, idexe_bubble, ifid_flush, back_freeze, state, mem_err};
  assign dut_cnt = {stall_cnt, flush_cnt, wait_cnt};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze),
    .idexe_bubble(idexe_bubble), .ifid_flush(ifid_flush), .back_freeze(back_freeze),
    .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_vec();
    int md;
    bit hold;
    md   = rst ? 0 : m_mode;
    hold = (md == 2) || (md == 0 && mem_req && !mem_ready) || (md == 1 && !mem_ready);
    return {hold || hazard_detected, hold || hazard_detected, !hold && hazard_detected,
            !hold && !hazard_detected && branch_taken, hold, 2'(md), (rst ? 1'b0 : m_err)};
  endfunction

  function automatic logic [3*CW-1:0] exp_cnt();
    if (!STATS) return '0;
    return {CW'(m_stall), CW'(m_flush), CW'(m_wait)};
  endfunction

  task automatic drive(input logic hz, input logic br, input logic req, input logic rdy, input logic rs);
    hazard_detected = hz;
    branch_taken    = br;
    mem_req         = req;
    mem_ready       = rdy;
    rst             = rs;
  endtask

  // advance one clock and move the model with the inputs seen at that edge
  task automatic tick();
    logic [7:0] v;
    @(posedge clk);
    v = exp_vec();
    if (rst) begin
      m_mode = 0; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      if (v[7] && m_stall < CMAX) m_stall++;
      if (v[4] && m_flush < CMAX) m_flush++;
      if (m_mode == 1 && !mem_ready && m_wait < CMAX) m_wait++;
      case (m_mode)
        0: if (mem_req && !mem_ready) begin m_mode = 1; m_waited = 0; end
        1: if (mem_ready) m_mode = 0;
           else begin
             m_waited++;
             if (m_waited == TO - 1) begin m_mode = 2; m_err = 1'b1; end
           end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 1);
    #1;
    checks++;
    if (dut_vec !== 8'b1100_1000) begin
      errors++; $display("FAIL reset_cycle_outputs got=%b want=%b", dut_vec, 8'b1100_1000);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000) begin
      errors++; $display("FAIL after_reset_outputs got=%b want=%b", dut_vec, 8'b0);
    end
    checks++;
    if (dut_cnt !== '0) begin
      errors++; $display("FAIL after_reset_counters got=%h want=0", dut_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b1110_0000) begin
      errors++; $display("FAIL load_use_stall got=%b want=%b", dut_vec, 8'b1110_0000);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000) begin
      errors++; $display("FAIL load_use_release got=%b want=%b", dut_vec, 8'b0);
    end
    checks++;
    if (stall_cnt !== (STATS ? CW'(1) : CW'(0))) begin
      errors++; $display("FAIL load_use_stall_cnt got=%0d want=%0d", stall_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    drive(1, 1, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b1110_0000) begin
      errors++; $display("FAIL branch_hazard_stall got=%b want=%b", dut_vec, 8'b1110_0000);
    end
    tick();
    drive(0, 1, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0001_0000) begin
      errors++; $display("FAIL branch_flush got=%b want=%b", dut_vec, 8'b0001_0000);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000) begin
      errors++; $display("FAIL branch_flush_one_cycle got=%b want=%b", dut_vec, 8'b0);
    end
    checks++;
    if (flush_cnt !== (STATS ? CW'(1) : CW'(0))) begin
      errors++; $display("FAIL branch_flush_cnt got=%0d want=%0d", flush_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] want [4] = '{8'b1100_1000, 8'b1100_1010, 8'b1100_1010, 8'b0000_0010};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      // hazard/branch during the freeze must be ignored
      drive(c == 1, c == 2, 1, c == 3, 0);
      #1;
      checks++;
      if (dut_vec !== want[c]) begin
        errors++; $display("FAIL mem_wait_cycle%0d got=%b want=%b", c + 1, dut_vec, want[c]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000) begin
      errors++; $display("FAIL mem_wait_return got=%b want=%b", dut_vec, 8'b0);
    end
    checks++;
    if (wait_cnt !== (STATS ? CW'(2) : CW'(0))) begin
      errors++; $display("FAIL mem_wait_cnt got=%0d want=%0d", wait_cnt, STATS ? 2 : 0);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] ws;
    logic       we;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c < 5) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0);
      else       drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      ws = (c >= 5) ? 2'd2 : ((c == 1) ? 2'd0 : 2'd1);
      we = (c >= 5);
      #1;
      checks++;
      if (dut_vec !== {5'b11001, ws, we}) begin
        errors++; $display("FAIL timeout_cycle%0d got=%b want=%b", c, dut_vec, {5'b11001, ws, we});
      end
      tick();
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      drive(0, 0, c < 5, c >= 4, 0);
      #1;
      checks++;
      if (c == 4 && dut_vec !== 8'b0000_0010) begin
        errors++; $display("FAIL timeout_race_release got=%b want=%b", dut_vec, 8'b0000_0010);
      end else if (c == 5 && dut_vec !== 8'b0000_0000) begin
        errors++; $display("FAIL timeout_race_run got=%b want=%b", dut_vec, 8'b0);
      end else if (c < 4 && dut_vec[0] !== 1'b0) begin
        errors++; $display("FAIL timeout_race_err cycle%0d got=%b want=0", c, dut_vec[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_recovery();
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    for (int c = 0; c < TO + 2; c++) begin drive(0, 0, 1, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (state !== 2'd2 || mem_err !== 1'b1 || dut_cnt !== exp_cnt()) begin
      errors++; $display("FAIL recovery_pre state=%0d err=%b cnt=%h want 2 1 %h", state, mem_err, dut_cnt, exp_cnt());
    end
    drive(0, 0, 0, 0, 1);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000) begin
      errors++; $display("FAIL recovery_reset_cycle got=%b want=%b", dut_vec, 8'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dut_vec !== 8'b0000_0000 || dut_cnt !== '0) begin
      errors++; $display("FAIL recovery_after got=%b cnt=%h want=0 cnt=0", dut_vec, dut_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < CMAX + 5; c++) begin drive(1, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall_cnt !== (STATS ? CW'(CMAX) : CW'(0))) begin
      errors++; $display("FAIL stall_cnt_saturate got=%0d want=%0d", stall_cnt, STATS ? CMAX : 0);
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(15, 80);
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) < rdy_pct),
            1'($urandom_range(0, 79) == 0));
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_outputs i=%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
      checks++;
      if (dut_cnt !== exp_cnt()) begin
        errors++; $display("FAIL random_counters i=%0d got=%h want=%h", i, dut_cnt, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_hazard();
    test_mem_wait();
    test_timeout();
    test_timeout_race();
    test_reset_recovery();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: cycles allowed in MEM_WAIT before ERROR (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port hazard_detected, input, 1: load-use or branch-operand hazard flagged for the ID-stage instruction.
REQ-006 SHALL have port branch_taken, input, 1: branch resolved taken in ID this cycle.
REQ-007 SHALL have port mem_req, input, 1: MEM-stage instruction is a load or store.
REQ-008 SHALL have port mem_ready, input, 1: data memory completes the MEM-stage access this cycle.
REQ-009 SHALL have port pc_freeze, output, 1: hold PC.
REQ-010 SHALL have port ifid_freeze, output, 1: hold the IF/ID register.
REQ-011 SHALL have port idexe_bubble, output, 1: load a NOP into ID/EXE.
REQ-012 SHALL have port ifid_flush, output, 1: clear IF/ID (squash the wrong-path fetch).
REQ-013 SHALL have port back_freeze, output, 1: hold the ID/EXE, EXE/MEM and MEM/WB registers.
REQ-014 SHALL have port state, output, 2: FSM state (RUN=0, MEM_WAIT=1, ERROR=2).
REQ-015 SHALL have port mem_err, output, 1: sticky memory-timeout flag.
REQ-016 SHALL have ports stall_cnt, flush_cnt and wait_cnt, output, CNT_W each: statistics counters.

Function
REQ-017 SHALL derive all control outputs combinationally from the current state and inputs; the FSM and counters SHALL be registered.
REQ-018 In RUN with mem_req=1 and mem_ready=0: SHALL assert pc_freeze, ifid_freeze and back_freeze; idexe_bubble=0; ifid_flush=0; next state MEM_WAIT.
REQ-019 In MEM_WAIT: SHALL keep pc_freeze, ifid_freeze and back_freeze asserted while mem_ready=0; when mem_ready=1, all freezes SHALL drop that same cycle and the next state SHALL be RUN.
REQ-020 A memory freeze SHALL take priority over hazard and branch handling; hazard_detected and branch_taken SHALL be ignored while any memory freeze is asserted.
REQ-021 In RUN with no memory freeze and hazard_detected=1: SHALL assert pc_freeze, ifid_freeze and idexe_bubble; ifid_flush=0.
REQ-022 In RUN with no memory freeze, hazard_detected=0 and branch_taken=1: SHALL assert ifid_flush only, for exactly that cycle.
REQ-023 An internal timer SHALL be cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle with mem_ready=0.
REQ-024 If the timer reaches MEM_TIMEOUT-1 while mem_ready=0, the next state SHALL be ERROR.
REQ-025 In ERROR: pc_freeze, ifid_freeze and back_freeze SHALL be asserted permanently; idexe_bubble=0; ifid_flush=0; mem_err=1; exit only via rst.
REQ-026 mem_ready=1 on the same cycle MEM_WAIT would hit the timeout SHALL win: the next state is RUN, not ERROR.

Reset
REQ-027 While rst=1 at a clock edge: state SHALL become RUN, and the timer, mem_err and all counters SHALL become 0; this applies mid-MEM_WAIT and in ERROR.
REQ-028 During a reset cycle, outputs SHALL reflect state RUN with the current inputs.

Configuration
REQ-029 With macro PIPE_STALL_STATS_EN defined:
- stall_cnt SHALL count cycles with pc_freeze=1.
- flush_cnt SHALL count cycles with ifid_flush=1.
- wait_cnt SHALL count MEM_WAIT cycles.
- All three counters SHALL saturate at 2^CNT_W-1.
REQ-030 Without PIPE_STALL_STATS_EN: stall_cnt, flush_cnt and wait_cnt SHALL be constant 0 and no counter flops SHALL be synthesized; all other behaviour unchanged.

Verification
REQ-031 Load-use stall: state RUN, hazard_detected=1 for 1 cycle, mem_req=0 -> pc_freeze=ifid_freeze=idexe_bubble=1 that cycle only; stall_cnt=1.
REQ-032 Branch vs hazard: branch_taken=1 with hazard_detected=1 -> stall only, ifid_flush=0; next cycle branch_taken=1, hazard_detected=0 -> ifid_flush=1; flush_cnt=1.
REQ-033 Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> back_freeze=1 for 3 cycles, 0 on the 4th; state returns to 0; wait_cnt=2.
REQ-034 Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> state=2 and mem_err=1 from cycle 5 onward; freezes remain 1.
REQ-035 Timeout race: MEM_TIMEOUT=4, mem_ready=1 on the 4th stall cycle -> state=0, mem_err=0.
REQ-036 Reset recovery: rst=1 for one cycle while in ERROR with counters non-zero -> state=0, mem_err=0, all counters 0 the next cycle.
